instr_fetch_decode: RTL and testbench
=====================================

# instr_fetch_decode

Instruction fetch and decode unit for the processor. It owns the program counter, reads instruction words from a synchronous instruction ROM, and decodes them into the one-hot operation flags consumed by the control FSM (`alu`, `ld`, `st`, `jump`, `cmpJump`, `cmpJumpEnable`). It then waits for the FSM's retire/redirect enables (`nextInstruction`, `enableJUMP`, `enableCMPJUMP`) before fetching the next word. It sits between the instruction ROM and the control FSM, and also drives register and ALU-op fields to the datapath.

## Interface
- `PC_W`, default 8, program counter and ROM address width; must be ≤ 12.
- `INSTR_W`, default 16, instruction word width; fixed at 16 for this encoding.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: synchronous, active-high reset.
- `imem_addr` out PC_W: ROM address (equals `pc`).
- `imem_rdata` in INSTR_W: ROM data, valid one cycle after the address.
- `cmp_eq` in 1: datapath comparator result, 1 when the compared registers are equal.
- `nextInstruction` in 1: FSM retire; advance PC by 1.
- `enableJUMP` in 1: FSM unconditional redirect.
- `enableCMPJUMP` in 1: FSM taken-branch redirect.
- `alu`, `ld`, `st`, `jump`, `cmpJump` out 1 each: registered one-hot operation flags.
- `cmpJumpEnable` out 1: branch-taken qualifier.
- `alu_op` out 3, `rd` out 4, `rs1` out 4, `rs2` out 4: decoded fields.
- `pc` out PC_W: current program counter.
- `halted` out 1: processor stopped.
- `illegal` out 1: sticky illegal-opcode flag (see Configuration).

## Operation
- Encoding: `op`=IR[15:12], `rd`=IR[11:8], `rs1`=IR[7:4], `rs2`=IR[3:0], jump target = IR[PC_W-1:0].
- Opcode map: 0 NOP; 1–7 ALU with `alu_op`=op[2:0]; 8 LD; 9 ST; A JMP; B BEQ; C BNE; F HALT; D and E illegal.
- Five states: FETCH, DECODE, ISSUE, HALTED, plus a RESET entry that behaves as FETCH.
- FETCH: drive `imem_addr`=`pc`; next state is DECODE.
- DECODE: IR ← `imem_rdata`.
  - NOP: `pc`←`pc`+1, go to FETCH.
  - HALT: go to HALTED.
  - Illegal: handled per Configuration.
  - Otherwise: set the matching flag and go to ISSUE.
- BEQ and BNE both raise `cmpJump`.
- ISSUE: hold the flag and the decoded fields stable until a retire event. On retire, clear all flags, update `pc`, and go to FETCH.
- Retire priority when several enables are high in the same cycle: `enableJUMP` > `enableCMPJUMP` > `nextInstruction`.
  - `enableJUMP` or `enableCMPJUMP`: `pc` ← target.
  - `nextInstruction`: `pc` ← `pc`+1.
- Enables are ignored in every state other than ISSUE.
- `cmpJumpEnable` is combinational: high only in ISSUE with `cmpJump`=1. It equals `cmp_eq` for BEQ and `!cmp_eq` for BNE.
- `pc`+1 wraps modulo 2^PC_W; `pc` at 2^PC_W−1 goes to 0.
- HALTED: all flags are 0, `halted`=1, and all enables are ignored. Only `reset` exits this state.

## Timing
- Reset values: `pc`=0, IR=0, all flags 0, `halted`=0, `illegal`=0, state FETCH, `imem_addr`=0.
- Reset asserted mid-instruction overrides everything on that edge.
- Fetch-to-issue latency: a retire sampled at edge E0 gives FETCH during [E0,E1), DECODE during [E1,E2), and the new flag high from E2. First instruction after reset release: flag high at the 2nd rising edge.
- Flags go low on the same edge at which the retire is sampled. The FSM therefore never samples a stale flag in the cycle following retire.
- A NOP costs 2 cycles and raises no flag.
- There is no timeout: ISSUE waits indefinitely for a retire event.

## Configuration
- `ILLEGAL_TRAP_EN` defined: an illegal opcode in DECODE sets `illegal`=1 (sticky until reset) and goes to HALTED, leaving `pc` at the faulting address.
- `ILLEGAL_TRAP_EN` undefined: an illegal opcode is executed as a NOP (`pc`+1, back to FETCH). The `illegal` output is tied to 0.

## Structure
- A shared package `isa_pkg` holds:
  - opcode localparams (OP_NOP, OP_LD, OP_ST, OP_JMP, OP_BEQ, OP_BNE, OP_HALT);
  - the field bit positions;
  - the state enum typedef.
- One natural sub-module, `instr_decoder`: purely combinational, IR → {class one-hot, `alu_op`, `rd`, `rs1`, `rs2`, `target`, `is_illegal`}. The top-level module holds the PC, IR and state register.

## Test plan
- Reset, with ROM[0]=0x1123 (ALU op 1): at edge 2, `alu`=1, `alu_op`=1, `rd`=1, `rs1`=2, `rs2`=3. Pulse `nextInstruction` → `alu`=0 on the same edge, `pc`=1.
- ROM[1]=0xA005 (JMP 5): `jump`=1. Assert `enableJUMP` and `nextInstruction` together → `pc`=5 (priority), next `imem_addr`=5.
- ROM[5]=0xB000 (BEQ 0) with `cmp_eq`=1 → `cmpJump`=1, `cmpJumpEnable`=1. `enableCMPJUMP` → `pc`=0. Repeat with `cmp_eq`=0 → `cmpJumpEnable`=0; `nextInstruction` → `pc`=6.
- `PC_W`=8, `pc`=0xFF holding 0x8000 (LD), retire → `pc`=0x00. ROM[0x00]=0x0000 (NOP) → no flag, `pc`=0x01 after 2 cycles.
- ROM word 0xD000 (illegal):
  - with `ILLEGAL_TRAP_EN`: `illegal`=1, `halted`=1, `pc` unchanged;
  - without it: treated as NOP.
  - ROM word 0xF000: `halted`=1, and enables are then ignored.
- Assert `reset` in ISSUE while `st`=1 → the next edge gives `st`=0, `pc`=0, state FETCH, and the first fetch is from address 0.

Source files
------------

// File: rtl/isa_pkg.sv
// Shared ISA definitions for the fetch/decode unit: opcodes, instruction
// field positions, decoded-class bit indices and the sequencer state type.
package isa_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LD   = 4'h8;
  localparam logic [3:0] OP_ST   = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_BEQ  = 4'hB;
  localparam logic [3:0] OP_BNE  = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 8;
  localparam int RS1_HI = 7;
  localparam int RS1_LO = 4;
  localparam int RS2_HI = 3;
  localparam int RS2_LO = 0;

  // Bit positions inside the decoder's one-hot class vector
  localparam int CLS_W    = 8;
  localparam int CLS_NOP  = 0;
  localparam int CLS_ALU  = 1;
  localparam int CLS_LD   = 2;
  localparam int CLS_ST   = 3;
  localparam int CLS_JMP  = 4;
  localparam int CLS_BEQ  = 5;
  localparam int CLS_BNE  = 6;
  localparam int CLS_HALT = 7;

  typedef enum logic [2:0] {
    ST_RESET,
    ST_FETCH,
    ST_DECODE,
    ST_ISSUE,
    ST_HALTED
  } state_t;

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational instruction decoder: splits a 16-bit word into its
// one-hot operation class, register fields, jump target and illegal marker.
module instr_decoder
  import isa_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16
) (
  input  logic [INSTR_W-1:0] i_ir,
  output logic [CLS_W-1:0]   o_class,
  output logic [2:0]         o_alu_op,
  output logic [3:0]         o_rd,
  output logic [3:0]         o_rs1,
  output logic [3:0]         o_rs2,
  output logic [PC_W-1:0]    o_target,
  output logic               o_is_illegal
);

  logic [3:0] w_op;

  assign w_op     = i_ir[OP_HI:OP_LO];
  assign o_alu_op = w_op[2:0];
  assign o_rd     = i_ir[RD_HI:RD_LO];
  assign o_rs1    = i_ir[RS1_HI:RS1_LO];
  assign o_rs2    = i_ir[RS2_HI:RS2_LO];
  assign o_target = i_ir[PC_W-1:0];

  // Opcodes 1-7 are ALU ops; the remaining unlisted codes (D, E) are illegal
  always_comb begin
    o_class      = '0;
    o_is_illegal = 1'b0;
    case (w_op)
      OP_NOP:  o_class[CLS_NOP]  = 1'b1;
      OP_LD:   o_class[CLS_LD]   = 1'b1;
      OP_ST:   o_class[CLS_ST]   = 1'b1;
      OP_JMP:  o_class[CLS_JMP]  = 1'b1;
      OP_BEQ:  o_class[CLS_BEQ]  = 1'b1;
      OP_BNE:  o_class[CLS_BNE]  = 1'b1;
      OP_HALT: o_class[CLS_HALT] = 1'b1;
      default: begin
        if (!w_op[3]) o_class[CLS_ALU] = 1'b1;
        else          o_is_illegal     = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_fetch_decode.sv
// Fetch/decode sequencer: owns PC, IR and state, raises one-hot operation
// flags and waits for the control FSM to retire. Macro ILLEGAL_TRAP_EN
// turns illegal opcodes into a sticky trap instead of a NOP.
module instr_fetch_decode
  import isa_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               cmp_eq,
  input  logic               nextInstruction,
  input  logic               enableJUMP,
  input  logic               enableCMPJUMP,
  output logic               alu,
  output logic               ld,
  output logic               st,
  output logic               jump,
  output logic               cmpJump,
  output logic               cmpJumpEnable,
  output logic [2:0]         alu_op,
  output logic [3:0]         rd,
  output logic [3:0]         rs1,
  output logic [3:0]         rs2,
  output logic [PC_W-1:0]    pc,
  output logic               halted,
  output logic               illegal
);

  state_t             r_state;
  state_t             w_stateNext;
  logic [PC_W-1:0]    r_pc;
  logic [PC_W-1:0]    w_pcNext;
  logic [PC_W-1:0]    w_pcInc;
  logic [INSTR_W-1:0] r_ir;
  logic [INSTR_W-1:0] w_irNext;
  logic               r_alu, r_ld, r_st, r_jump, r_cmpJump;
  logic               w_aluNext, w_ldNext, w_stNext, w_jumpNext, w_cmpJumpNext;

  logic [INSTR_W-1:0] w_decIn;
  logic [CLS_W-1:0]   w_class;
  logic [PC_W-1:0]    w_target;
  logic               w_isIllegal;

`ifdef ILLEGAL_TRAP_EN
  logic               r_illegal;
  logic               w_illegalNext;
`endif

  // In DECODE the word comes straight from the ROM; afterwards the latched IR
  // keeps the fields stable while the FSM works on the instruction.
  assign w_decIn = (r_state == ST_DECODE) ? imem_rdata : r_ir;

  instr_decoder #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_decoder (
    .i_ir         (w_decIn),
    .o_class      (w_class),
    .o_alu_op     (alu_op),
    .o_rd         (rd),
    .o_rs1        (rs1),
    .o_rs2        (rs2),
    .o_target     (w_target),
    .o_is_illegal (w_isIllegal)
  );

  assign w_pcInc = r_pc + PC_W'(1);

  always_comb begin
    w_stateNext   = r_state;
    w_pcNext      = r_pc;
    w_irNext      = r_ir;
    w_aluNext     = r_alu;
    w_ldNext      = r_ld;
    w_stNext      = r_st;
    w_jumpNext    = r_jump;
    w_cmpJumpNext = r_cmpJump;
`ifdef ILLEGAL_TRAP_EN
    w_illegalNext = r_illegal;
`endif
    case (r_state)
      ST_RESET, ST_FETCH: w_stateNext = ST_DECODE;
      ST_DECODE: begin
        w_irNext = imem_rdata;
        if (w_class[CLS_HALT]) begin
          w_stateNext = ST_HALTED;
        end else if (w_isIllegal) begin
`ifdef ILLEGAL_TRAP_EN
          w_illegalNext = 1'b1;
          w_stateNext   = ST_HALTED;
`else
          w_pcNext    = w_pcInc;
          w_stateNext = ST_FETCH;
`endif
        end else if (w_class[CLS_NOP]) begin
          w_pcNext    = w_pcInc;
          w_stateNext = ST_FETCH;
        end else begin
          w_aluNext     = w_class[CLS_ALU];
          w_ldNext      = w_class[CLS_LD];
          w_stNext      = w_class[CLS_ST];
          w_jumpNext    = w_class[CLS_JMP];
          w_cmpJumpNext = w_class[CLS_BEQ] | w_class[CLS_BNE];
          w_stateNext   = ST_ISSUE;
        end
      end
      // Redirects outrank a plain retire when several enables coincide
      ST_ISSUE: begin
        if (enableJUMP || enableCMPJUMP || nextInstruction) begin
          w_pcNext      = (enableJUMP || enableCMPJUMP) ? w_target : w_pcInc;
          w_aluNext     = 1'b0;
          w_ldNext      = 1'b0;
          w_stNext      = 1'b0;
          w_jumpNext    = 1'b0;
          w_cmpJumpNext = 1'b0;
          w_stateNext   = ST_FETCH;
        end
      end
      ST_HALTED: w_stateNext = ST_HALTED;
      default:   w_stateNext = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_FETCH;
      r_pc      <= '0;
      r_ir      <= '0;
      r_alu     <= 1'b0;
      r_ld      <= 1'b0;
      r_st      <= 1'b0;
      r_jump    <= 1'b0;
      r_cmpJump <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_pc      <= w_pcNext;
      r_ir      <= w_irNext;
      r_alu     <= w_aluNext;
      r_ld      <= w_ldNext;
      r_st      <= w_stNext;
      r_jump    <= w_jumpNext;
      r_cmpJump <= w_cmpJumpNext;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  always_ff @(posedge clk) begin
    if (reset) r_illegal <= 1'b0;
    else       r_illegal <= w_illegalNext;
  end
  assign illegal = r_illegal;
`else
  assign illegal = 1'b0;
`endif

  assign imem_addr     = r_pc;
  assign pc            = r_pc;
  assign alu           = r_alu;
  assign ld            = r_ld;
  assign st            = r_st;
  assign jump          = r_jump;
  assign cmpJump       = r_cmpJump;
  assign halted        = (r_state == ST_HALTED);
  assign cmpJumpEnable = (r_state == ST_ISSUE) && r_cmpJump &&
                         (w_class[CLS_BNE] ? !cmp_eq : cmp_eq);

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Directed bench for instr_fetch_decode with a synchronous ROM model;
// expectations are hand-derived from the ISA and the fetch/decode timing.
module tb_instr_fetch_decode;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        cmp_eq;
  logic        nextInstruction, enableJUMP, enableCMPJUMP;
  logic        alu, ld, st, jump, cmpJump, cmpJumpEnable;
  logic [2:0]  alu_op;
  logic [3:0]  rd, rs1, rs2;
  logic [7:0]  pc;
  logic        halted, illegal;
  logic [4:0]  flags;

  logic [15:0] rom [256];
  int          total = 0;
  int          bad = 0;

  instr_fetch_decode #(.PC_W(8), .INSTR_W(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .cmp_eq          (cmp_eq),
    .nextInstruction (nextInstruction),
    .enableJUMP      (enableJUMP),
    .enableCMPJUMP   (enableCMPJUMP),
    .alu             (alu),
    .ld              (ld),
    .st              (st),
    .jump            (jump),
    .cmpJump         (cmpJump),
    .cmpJumpEnable   (cmpJumpEnable),
    .alu_op          (alu_op),
    .rd              (rd),
    .rs1             (rs1),
    .rs2             (rs2),
    .pc              (pc),
    .halted          (halted),
    .illegal         (illegal)
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_rdata <= rom[imem_addr];

  assign flags = {alu, ld, st, jump, cmpJump};

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic n, input logic j, input logic c);
    nextInstruction = n;
    enableJUMP      = j;
    enableCMPJUMP   = c;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset  = 1'b1;
    cmp_eq = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    rom[0]     = 16'h1123;
    rom[1]     = 16'hA005;
    rom[5]     = 16'hB000;
    rom[6]     = 16'hC0FF;
    rom[8'hFF] = 16'h8000;

    waitCycles(2);
    checkOutput("rst_pc", 32'(pc), 32'h0);
    checkOutput("rst_flags", 32'(flags), 32'h0);
    checkOutput("rst_halted", 32'(halted), 32'h0);
    checkOutput("rst_illegal", 32'(illegal), 32'h0);
    checkOutput("rst_addr", 32'(imem_addr), 32'h0);

    reset = 1'b0;
    waitCycles(2);
    checkOutput("alu_flags", 32'(flags), 32'b10000);
    checkOutput("alu_op", 32'(alu_op), 32'h1);
    checkOutput("alu_rd", 32'(rd), 32'h1);
    checkOutput("alu_rs1", 32'(rs1), 32'h2);
    checkOutput("alu_rs2", 32'(rs2), 32'h3);

    applyStimulus(1'b1, 1'b0, 1'b0);
    waitCycles(1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("alu_retire_flags", 32'(flags), 32'h0);
    checkOutput("alu_retire_pc", 32'(pc), 32'h1);

    waitCycles(2);
    checkOutput("jmp_flags", 32'(flags), 32'b00010);
    applyStimulus(1'b1, 1'b1, 1'b0);
    waitCycles(1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("jmp_retire_flags", 32'(flags), 32'h0);
    checkOutput("jmp_prio_pc", 32'(pc), 32'h5);
    checkOutput("jmp_addr", 32'(imem_addr), 32'h5);

    cmp_eq = 1'b1;
    waitCycles(2);
    checkOutput("beq_flags", 32'(flags), 32'b00001);
    checkOutput("beq_taken", 32'(cmpJumpEnable), 32'h1);
    cmp_eq = 1'b0;
    #1;
    checkOutput("beq_live_ne", 32'(cmpJumpEnable), 32'h0);
    cmp_eq = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1);
    waitCycles(1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("beq_redirect_pc", 32'(pc), 32'h0);
    checkOutput("beq_retire_cje", 32'(cmpJumpEnable), 32'h0);

    waitCycles(2);
    checkOutput("alu2_flags", 32'(flags), 32'b10000);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitCycles(1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitCycles(2);
    checkOutput("jmp2_flags", 32'(flags), 32'b00010);
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitCycles(1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("jmp2_pc", 32'(pc), 32'h5);

    cmp_eq = 1'b0;
    waitCycles(2);
    checkOutput("beq2_flags", 32'(flags), 32'b00001);
    checkOutput("beq2_not_taken", 32'(cmpJumpEnable), 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitCycles(1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("beq2_fall_pc", 32'(pc), 32'h6);

    waitCycles(2);
    checkOutput("bne_flags", 32'(flags), 32'b00001);
    checkOutput("bne_taken", 32'(cmpJumpEnable), 32'h1);
    cmp_eq = 1'b1;
    #1;
    checkOutput("bne_live_eq", 32'(cmpJumpEnable), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    waitCycles(1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("bne_redirect_pc", 32'(pc), 32'hFF);
    rom[0] = 16'h0000;
    rom[1] = 16'hF000;

    waitCycles(2);
    checkOutput("ld_flags", 32'(flags), 32'b01000);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitCycles(1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("pc_wrap", 32'(pc), 32'h0);

    waitCycles(2);
    checkOutput("nop_pc", 32'(pc), 32'h1);
    checkOutput("nop_flags", 32'(flags), 32'h0);

    waitCycles(2);
    checkOutput("halt_halted", 32'(halted), 32'h1);
    checkOutput("halt_pc", 32'(pc), 32'h1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    waitCycles(2);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("halt_ignore_pc", 32'(pc), 32'h1);
    checkOutput("halt_ignore_halted", 32'(halted), 32'h1);
    checkOutput("halt_ignore_flags", 32'(flags), 32'h0);

    rom[0] = 16'h9321;
    reset  = 1'b1;
    waitCycles(1);
    reset  = 1'b0;
    checkOutput("halt_exit_halted", 32'(halted), 32'h0);
    checkOutput("halt_exit_pc", 32'(pc), 32'h0);

    waitCycles(2);
    checkOutput("st_flags", 32'(flags), 32'b00100);
    checkOutput("st_rd", 32'(rd), 32'h3);
    checkOutput("st_rs1", 32'(rs1), 32'h2);
    checkOutput("st_rs2", 32'(rs2), 32'h1);

    rom[0] = 16'hD000;
    reset  = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitCycles(1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    checkOutput("midrst_flags", 32'(flags), 32'h0);
    checkOutput("midrst_pc", 32'(pc), 32'h0);
    checkOutput("midrst_addr", 32'(imem_addr), 32'h0);

    waitCycles(2);
`ifdef ILLEGAL_TRAP_EN
    checkOutput("illegal_flag", 32'(illegal), 32'h1);
    checkOutput("illegal_halted", 32'(halted), 32'h1);
    checkOutput("illegal_pc", 32'(pc), 32'h0);
`else
    checkOutput("illegal_flag", 32'(illegal), 32'h0);
    checkOutput("illegal_halted", 32'(halted), 32'h0);
    checkOutput("illegal_pc", 32'(pc), 32'h1);
`endif
    checkOutput("illegal_flags", 32'(flags), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
